// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and pointer-wrap helper for the round-robin mux.
package mux_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int MAX_N = 16;
  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: request side and output side handshake bundle of rr_mux_n.
interface rr_mux_n_if import mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = 4
);
  localparam int SELW = $clog2(N);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_sel;
  logic out_valid;
  logic out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_sel, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_sel, out_valid);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);
  logic hit_hi, hit_lo;
  logic [SELW-1:0] idx_hi, idx_lo;
  // Descending scan leaves the lowest requester overall and the lowest at/after ptr.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_lo = 1'b1;
        idx_lo = SELW'(i);
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = SELW'(i);
        end
      end
    end
  end
  assign grant_idx = hit_hi ? idx_hi : idx_lo;
  assign grant = (enable && hit_lo) ? N'(1) << grant_idx : '0;
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel round-robin arbitrating mux with a registered output stage.
// Define RR_MUX_SKID_EN to add a one-entry skid register that removes the out_ready->in_ready path.
module rr_mux_n import mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input logic clk,
  input logic reset,
  rr_mux_n_if.slave bus
);
  logic [SELW-1:0] ptr, grant_idx, sel_q;
  logic [N-1:0] grant;
  logic [WIDTH-1:0] sel_data, data_q;
  logic valid_q, enable, accept, drain;
  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("rr_mux_n: N must be in 2..%0d", MAX_N);
  end
  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req(bus.in_valid),
    .ptr(ptr),
    .enable(enable),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end
  assign accept = |grant;
  assign drain = valid_q && bus.out_ready;
`ifdef RR_MUX_SKID_EN
  logic skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0] skid_sel;
  assign enable = !reset && !skid_full;
  // A full skid blocks new accepts, so it only ever has to move forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_sel <= '0;
    end else if (skid_full) begin
      if (drain) begin
        data_q <= skid_data;
        sel_q <= skid_sel;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (!valid_q || drain) begin
        data_q <= sel_data;
        sel_q <= grant_idx;
        valid_q <= 1'b1;
      end else begin
        skid_data <= sel_data;
        skid_sel <= grant_idx;
        skid_full <= 1'b1;
      end
    end else if (drain) valid_q <= 1'b0;
  end
`else
  assign enable = !reset && (!valid_q || bus.out_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
    end else if (accept) begin
      data_q <= sel_data;
      sel_q <= grant_idx;
      valid_q <= 1'b1;
    end else if (drain) valid_q <= 1'b0;
  end
`endif
  always_ff @(posedge clk) ptr <= reset ? '0 : accept ? SELW'(next_ptr(32'(grant_idx), N)) : ptr;
  assign bus.in_ready = grant;
  assign bus.out_data = data_q;
  assign bus.out_sel = sel_q;
  assign bus.out_valid = valid_q;
endmodule
